// File: rtl/mycpu_pkg.sv
// Shared execute-unit types: opcodes, FSM states, flag bit positions.
// EU_DIV_EN (optional) turns on the iterative divider in eu_seq.
package mycpu_pkg;

  localparam int EU_ITER = 16;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SRA  = 4'd8,
    OP_PASS = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIV  = 4'd11
  } eu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } eu_state_t;

  function automatic logic [3:0] pack_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/eu_alu_comb.sv
// Single-cycle ALU datapath and flag generation for the execute unit.
// Purely combinational; legal=0 for anything it cannot finish in one cycle.
module eu_alu_comb
  import mycpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic [3:0]    flags,
  output logic          legal
);

  logic [DW:0] sum;
  logic [3:0]  sh;
  logic        c;
  logic        v;

  always_comb begin
    sh    = b[3:0];
    sum   = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    legal = 1'b1;
    unique case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        sum = {1'b0, a} - {1'b0, b};
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      OP_SRA:  res = DW'($signed(a) >>> sh);
      OP_PASS: res = b;
      default: legal = 1'b0;
    endcase
    flags = pack_flags(~|res, res[DW-1], c, v);
  end

endmodule

// File: rtl/eu_seq.sv
// Multi-cycle execute unit: ALU ops in 1 cycle, shift-add MUL in 16 steps.
// Define EU_DIV_EN to add 16-step restoring DIV (op 11); else op 11 is illegal.
module eu_seq
  import mycpu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ITER = EU_ITER
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_in,
  input  logic [3:0]    op_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] d_out,
  output logic          rw_out,
  output logic          done_out,
  output logic          busy_out,
  output logic [3:0]    flags_out
);

  eu_state_t     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] d_d;
  logic [3:0]    flg_d;
  logic          rw_d, done_d;

  logic [DW-1:0] alu_res;
  logic [3:0]    alu_flg;
  logic          alu_legal;

  eu_alu_comb #(.DW(DW)) u_alu (
    .op    (op_in),
    .a     (a_in),
    .b     (b_in),
    .res   (alu_res),
    .flags (alu_flg),
    .legal (alu_legal)
  );

  // {hi,lo} holds the partial product, multiplier starts in lo
  logic [DW:0]   m_sum;
  logic [DW-1:0] m_hi, m_lo;
  logic          last;

  assign m_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign m_hi  = m_sum[DW:1];
  assign m_lo  = {m_sum[0], lo_q[DW-1:1]};
  assign last  = (cnt_q == 4'(ITER - 1));

`ifdef EU_DIV_EN
  // hi is the running remainder, lo shifts dividend out and quotient in
  logic [DW:0]   v_sh, v_dif;
  logic          v_ge;
  logic [DW-1:0] v_rem, v_quo;

  assign v_sh  = {hi_q, lo_q[DW-1]};
  assign v_dif = v_sh - {1'b0, a_q};
  assign v_ge  = (v_sh >= {1'b0, a_q});
  assign v_rem = v_ge ? v_dif[DW-1:0] : v_sh[DW-1:0];
  assign v_quo = {lo_q[DW-2:0], v_ge};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_out;
    flg_d   = flags_out;
    rw_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          unique case (1'b1)
            (op_in == OP_MUL): begin
              state_d = MUL;
              cnt_d   = '0;
              a_d     = a_in;
              hi_d    = '0;
              lo_d    = b_in;
            end
`ifdef EU_DIV_EN
            (op_in == OP_DIV): begin
              state_d = DIV;
              cnt_d   = '0;
              a_d     = b_in;
              hi_d    = '0;
              lo_d    = a_in;
            end
`endif
            default: begin
              done_d = 1'b1;
              if (alu_legal) begin
                rw_d  = 1'b1;
                d_d   = alu_res;
                flg_d = alu_flg;
              end
            end
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q + 4'd1;
        hi_d  = m_hi;
        lo_d  = m_lo;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rw_d    = 1'b1;
          d_d     = m_lo;
          flg_d   = pack_flags(~|m_lo, m_lo[DW-1], |m_hi, 1'b0);
        end
      end
`ifdef EU_DIV_EN
      DIV: begin
        cnt_d = cnt_q + 4'd1;
        hi_d  = v_rem;
        lo_d  = v_quo;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rw_d    = 1'b1;
          if (a_q == '0) begin
            d_d   = '1;
            flg_d = pack_flags(1'b0, 1'b1, 1'b0, 1'b1);
          end else begin
            d_d   = v_quo;
            flg_d = pack_flags(~|v_quo, v_quo[DW-1], |v_rem, 1'b0);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      d_out     <= '0;
      flags_out <= '0;
      rw_out    <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      d_out     <= d_d;
      flags_out <= flg_d;
      rw_out    <= rw_d;
      done_out  <= done_d;
    end
  end

  assign busy_out = (state_q != IDLE);

endmodule
